// File: rtl/lcd_init_ctrl.sv
// HD44780-style 4-bit LCD power-on initialiser: timed nibble pulses, then DONE hands the bus downstream.
// Optional macro LCD_INIT_CONFIG_EN appends the 0x28/0x06/0x0C/0x01 configuration byte writes.
module lcd_init_ctrl #(
    parameter int unsigned CLK_MHZ = 50,
    parameter int unsigned E_PULSE = 12,
    parameter int unsigned CNT_W   = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    output logic [3:0] SF_D,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       init_done,
    output logic       busy
);

    localparam int unsigned T_POR  = 15000 * CLK_MHZ;
    localparam int unsigned T_4100 = 4100 * CLK_MHZ;
    localparam int unsigned T_100  = 100 * CLK_MHZ;
    localparam int unsigned T_40   = 40 * CLK_MHZ;
`ifdef LCD_INIT_CONFIG_EN
    localparam int unsigned T_1640 = 1640 * CLK_MHZ;
    localparam int unsigned T_1US  = 1 * CLK_MHZ;
`endif

    typedef enum logic [4:0] {
        S_POR_WAIT, S_PULSE0, S_WAIT0, S_PULSE1, S_WAIT1,
        S_PULSE2, S_WAIT2, S_PULSE3, S_WAIT3,
`ifdef LCD_INIT_CONFIG_EN
        S_C0_PH, S_C0_WH, S_C0_PL, S_C0_WL,
        S_C1_PH, S_C1_WH, S_C1_PL, S_C1_WL,
        S_C2_PH, S_C2_WH, S_C2_PL, S_C2_WL,
        S_C3_PH, S_C3_WH, S_C3_PL, S_C3_WL,
`endif
        S_DONE
    } state_t;

    state_t             state, state_nxt, succ;
    logic [CNT_W-1:0]   cnt, cnt_nxt, dur;
    logic [3:0]         nib, sf_d_nxt;

    function automatic logic is_pulse(input state_t s);
        case (s)
            S_PULSE0, S_PULSE1, S_PULSE2, S_PULSE3: return 1'b1;
`ifdef LCD_INIT_CONFIG_EN
            S_C0_PH, S_C0_PL, S_C1_PH, S_C1_PL,
            S_C2_PH, S_C2_PL, S_C3_PH, S_C3_PL: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Per-state duration, successor and the nibble presented for the following pulse
    always_comb begin
        dur  = CNT_W'(E_PULSE);
        succ = S_DONE;
        nib  = 4'h0;
        case (state)
            S_POR_WAIT: begin dur = CNT_W'(T_POR);  succ = S_PULSE0; nib = 4'h3; end
            S_PULSE0:   succ = S_WAIT0;
            S_WAIT0:    begin dur = CNT_W'(T_4100); succ = S_PULSE1; nib = 4'h3; end
            S_PULSE1:   succ = S_WAIT1;
            S_WAIT1:    begin dur = CNT_W'(T_100);  succ = S_PULSE2; nib = 4'h3; end
            S_PULSE2:   succ = S_WAIT2;
            S_WAIT2:    begin dur = CNT_W'(T_40);   succ = S_PULSE3; nib = 4'h2; end
            S_PULSE3:   succ = S_WAIT3;
`ifdef LCD_INIT_CONFIG_EN
            S_WAIT3:    begin dur = CNT_W'(T_40);   succ = S_C0_PH;  nib = 4'h2; end
            S_C0_PH:    succ = S_C0_WH;
            S_C0_WH:    begin dur = CNT_W'(T_1US);  succ = S_C0_PL;  nib = 4'h8; end
            S_C0_PL:    succ = S_C0_WL;
            S_C0_WL:    begin dur = CNT_W'(T_40);   succ = S_C1_PH;  nib = 4'h0; end
            S_C1_PH:    succ = S_C1_WH;
            S_C1_WH:    begin dur = CNT_W'(T_1US);  succ = S_C1_PL;  nib = 4'h6; end
            S_C1_PL:    succ = S_C1_WL;
            S_C1_WL:    begin dur = CNT_W'(T_40);   succ = S_C2_PH;  nib = 4'h0; end
            S_C2_PH:    succ = S_C2_WH;
            S_C2_WH:    begin dur = CNT_W'(T_1US);  succ = S_C2_PL;  nib = 4'hC; end
            S_C2_PL:    succ = S_C2_WL;
            S_C2_WL:    begin dur = CNT_W'(T_40);   succ = S_C3_PH;  nib = 4'h0; end
            S_C3_PH:    succ = S_C3_WH;
            S_C3_WH:    begin dur = CNT_W'(T_1US);  succ = S_C3_PL;  nib = 4'h1; end
            S_C3_PL:    succ = S_C3_WL;
            S_C3_WL:    begin dur = CNT_W'(T_1640); succ = S_DONE;   nib = 4'h0; end
`else
            S_WAIT3:    begin dur = CNT_W'(T_40);   succ = S_DONE;   nib = 4'h0; end
`endif
            default:    ;
        endcase
    end

    // Next state, shared counter and data nibble; the nibble moves one cycle after a wait begins
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sf_d_nxt  = SF_D;
        if (state == S_DONE) begin
            if (restart) begin
                state_nxt = S_POR_WAIT;
                cnt_nxt   = '0;
            end
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == dur - CNT_W'(1)) begin
                state_nxt = succ;
                cnt_nxt   = '0;
            end
            if (!is_pulse(state) && cnt == '0) begin
                sf_d_nxt = nib;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_POR_WAIT;
            cnt       <= '0;
            SF_D      <= 4'h0;
            LCD_E     <= 1'b0;
            init_done <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            SF_D      <= sf_d_nxt;
            LCD_E     <= is_pulse(state_nxt);
            init_done <= (state_nxt == S_DONE);
            busy      <= (state_nxt != S_DONE);
        end
    end

    assign LCD_RS = 1'b0;
    assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_init_ctrl.sv
// Directed bench for lcd_init_ctrl, run at CLK_MHZ=1 so every timed state is short.
module tb_lcd_init_ctrl;

    localparam int unsigned CLK_MHZ = 1;
    localparam int unsigned E_PULSE = 12;
    localparam int unsigned CNT_W   = 14;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic [3:0] sf_d;
    logic       lcd_e, lcd_rs, lcd_rw, init_done, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcd_init_ctrl #(.CLK_MHZ(CLK_MHZ), .E_PULSE(E_PULSE), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .SF_D     (sf_d),
        .LCD_E    (lcd_e),
        .LCD_RS   (lcd_rs),
        .LCD_RW   (lcd_rw),
        .init_done(init_done),
        .busy     (busy)
    );

    // Reset with restart also high: reset state must hold
    task automatic test_reset();
        reset = 1'b1;
        restart = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (sf_d !== 4'h0) begin errors++; $display("FAIL reset_sf_d: got %h expected 0", sf_d); end
        checks++; if (lcd_e !== 1'b0) begin errors++; $display("FAIL reset_lcd_e: got %b expected 0", lcd_e); end
        checks++; if (lcd_rs !== 1'b0) begin errors++; $display("FAIL reset_lcd_rs: got %b expected 0", lcd_rs); end
        checks++; if (lcd_rw !== 1'b0) begin errors++; $display("FAIL reset_lcd_rw: got %b expected 0", lcd_rw); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        restart = 1'b0;
    endtask

    // Full power-on sequence; restart pulses mid-sequence must be ignored
    task automatic test_power_on();
        int         exp_rise[4]    = '{15000, 19112, 19224, 19276};
        int         exp_fall[4]    = '{15012, 19124, 19236, 19288};
        logic [3:0] exp_pd[4]      = '{4'h3, 4'h3, 4'h3, 4'h2};
        int         exp_chg_cyc[3] = '{1, 19237, 19289};
        logic [3:0] exp_chg_val[3] = '{4'h3, 4'h2, 4'h0};
        int         rise_q[$];
        int         fall_q[$];
        int         chg_cyc_q[$];
        logic [3:0] pd_q[$];
        logic [3:0] chg_val_q[$];
        int         done_cyc = -1;
        int         rsrw_bad = 0;
        int         got;
        logic [3:0] got_d;
        logic       prev_e;
        logic [3:0] prev_d;
        reset = 1'b0;
        prev_e = lcd_e;
        prev_d = sf_d;
        for (int cyc = 0; cyc < 25000; cyc++) begin
            restart = (cyc == 5000 || cyc == 15005 || cyc == 19300);
            if (lcd_e && !prev_e) begin rise_q.push_back(cyc); pd_q.push_back(sf_d); end
            if (!lcd_e && prev_e) fall_q.push_back(cyc);
            if (sf_d !== prev_d) begin chg_cyc_q.push_back(cyc); chg_val_q.push_back(sf_d); end
            if (lcd_rs !== 1'b0 || lcd_rw !== 1'b0) rsrw_bad++;
            prev_e = lcd_e;
            prev_d = sf_d;
            if (init_done === 1'b1) begin done_cyc = cyc; break; end
            @(negedge clk);
        end
        restart = 1'b0;
        checks++; if (done_cyc != 19328) begin errors++; $display("FAIL init_done_cycle: got %0d expected 19328", done_cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b expected 0", busy); end
        checks++; if (lcd_e !== 1'b0) begin errors++; $display("FAIL done_lcd_e: got %b expected 0", lcd_e); end
        checks++; if (sf_d !== 4'h0) begin errors++; $display("FAIL done_sf_d: got %h expected 0", sf_d); end
        checks++; if (rsrw_bad != 0) begin errors++; $display("FAIL rs_rw_low: got %0d bad cycles expected 0", rsrw_bad); end
        checks++; if (rise_q.size() != 4) begin errors++; $display("FAIL pulse_count: got %0d expected 4", rise_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < rise_q.size()) ? rise_q[i] : -1;
            checks++; if (got != exp_rise[i]) begin errors++; $display("FAIL e_rise[%0d]: got %0d expected %0d", i, got, exp_rise[i]); end
            got = (i < fall_q.size()) ? fall_q[i] : -1;
            checks++; if (got != exp_fall[i]) begin errors++; $display("FAIL e_fall[%0d]: got %0d expected %0d", i, got, exp_fall[i]); end
            got_d = (i < pd_q.size()) ? pd_q[i] : 4'hx;
            checks++; if (got_d !== exp_pd[i]) begin errors++; $display("FAIL pulse_nibble[%0d]: got %h expected %h", i, got_d, exp_pd[i]); end
        end
        checks++; if (chg_cyc_q.size() != 3) begin errors++; $display("FAIL sf_d_changes: got %0d expected 3", chg_cyc_q.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < chg_cyc_q.size()) ? chg_cyc_q[i] : -1;
            checks++; if (got != exp_chg_cyc[i]) begin errors++; $display("FAIL sf_d_chg_cyc[%0d]: got %0d expected %0d", i, got, exp_chg_cyc[i]); end
            got_d = (i < chg_val_q.size()) ? chg_val_q[i] : 4'hx;
            checks++; if (got_d !== exp_chg_val[i]) begin errors++; $display("FAIL sf_d_chg_val[%0d]: got %h expected %h", i, got_d, exp_chg_val[i]); end
        end
    endtask

    // DONE holds until restart, which re-runs the whole sequence; stops mid second pulse
    task automatic test_restart();
        int rise_q[$];
        int done_hi = 0;
        int got;
        logic prev_e;
        repeat (5) @(negedge clk);
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL done_hold_init_done: got %b expected 1", init_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_hold_busy: got %b expected 0", busy); end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL restart_init_done: got %b expected 0", init_done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b expected 1", busy); end
        prev_e = lcd_e;
        for (int cyc = 0; cyc < 19115; cyc++) begin
            if (lcd_e && !prev_e) rise_q.push_back(cyc);
            if (init_done !== 1'b0) done_hi++;
            prev_e = lcd_e;
            @(negedge clk);
        end
        got = (rise_q.size() > 0) ? rise_q[0] : -1;
        checks++; if (got != 15000) begin errors++; $display("FAIL restart_rise0: got %0d expected 15000", got); end
        got = (rise_q.size() > 1) ? rise_q[1] : -1;
        checks++; if (got != 19112) begin errors++; $display("FAIL restart_rise1: got %0d expected 19112", got); end
        checks++; if (done_hi != 0) begin errors++; $display("FAIL restart_init_done_low: got %0d high cycles expected 0", done_hi); end
    endtask

    // Reset during an E pulse drops E at once and restarts from POR_WAIT
    task automatic test_reset_mid_pulse();
        int first_rise = -1;
        logic prev_e;
        checks++; if (lcd_e !== 1'b1) begin errors++; $display("FAIL mid_pulse_e_high: got %b expected 1", lcd_e); end
        reset = 1'b1;
        restart = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        restart = 1'b0;
        checks++; if (lcd_e !== 1'b0) begin errors++; $display("FAIL mid_reset_lcd_e: got %b expected 0", lcd_e); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_reset_busy: got %b expected 1", busy); end
        checks++; if (sf_d !== 4'h0) begin errors++; $display("FAIL mid_reset_sf_d: got %h expected 0", sf_d); end
        prev_e = lcd_e;
        for (int cyc = 0; cyc < 16000; cyc++) begin
            if (lcd_e && !prev_e) begin first_rise = cyc; break; end
            prev_e = lcd_e;
            @(negedge clk);
        end
        checks++; if (first_rise != 15000) begin errors++; $display("FAIL mid_reset_next_rise: got %0d expected 15000", first_rise); end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_restart();
        test_reset_mid_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
